// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : binary_to_bcd_seq
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3 /
//             double-dabble), one input bit per clock.
//             Valid/ready handshakes on both sides.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH   binary input width in bits (1..32)
//    DIGITS  number of BCD output digits (1..10)
//  Ports
//    clk_i        system clock, rising edge
//    rst_i        synchronous active-high reset
//    in_valid_i   binary_in_i holds a value to convert
//    in_ready_o   converter can accept (IDLE and not in reset)
//    binary_in_i  unsigned binary value, sampled on in_valid_i && in_ready_o
//    out_valid_o  bcd_out_o / bcd_ovf_o hold a finished result
//    out_ready_i  downstream accepts the result
//    bcd_out_o    packed BCD, digit 0 (units) in bits [3:0]
//    bcd_ovf_o    value >= 10^DIGITS; bcd_out_o is then value mod 10^DIGITS
// ============================================================================
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      binary_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   bcd_out_o,
  output logic                  bcd_ovf_o
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   bin_sr_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   bcd_q;
  logic               bcd_ovf_q;

  // Next-state values of the shift datapath
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic               carry_d;
  logic [WIDTH-1:0]   bin_sr_d;
  logic               ovf_d;

  // Add-3 correction: any digit >= 5 would become >= 10 after doubling,
  // so bias it by 3 first so the doubling carries into the next digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    assign acc_adj[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5) ?
                               (acc_q[4*g +: 4] + 4'd3) : acc_q[4*g +: 4];
  end

  // Shift the corrected accumulator left, pulling in the next binary bit.
  // The bit falling out of the top digit means the value no longer fits.
  assign {carry_d, acc_d} = {acc_adj, bin_sr_q[WIDTH-1]};
  assign bin_sr_d         = bin_sr_q << 1;
  assign ovf_d            = ovf_q | carry_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bin_sr_q  <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      bcd_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid_i) begin
            bin_sr_q <= binary_in_i;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= CNT_LOAD;
            state_q  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          bin_sr_q <= bin_sr_d;
          acc_q    <= acc_d;
          ovf_q    <= ovf_d;
          if (cnt_q == '0) begin
            // Last bit consumed: publish the result, held until next finish
            bcd_q     <= acc_d;
            bcd_ovf_q <= ovf_d;
            state_q   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (out_ready_i) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags come straight from state; in_ready is also masked by
  // reset so nothing is accepted while reset is being held.
  assign in_ready_o  = (state_q == ST_IDLE) && !rst_i;
  assign out_valid_o = (state_q == ST_DONE);
  assign bcd_out_o   = bcd_q;
  assign bcd_ovf_o   = bcd_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_binary_to_bcd_seq
//  Purpose  : Scoreboard bench for binary_to_bcd_seq in three configurations
//             (8b/3 digits, 8b/2 digits with overflow, 16b/5 digits).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] done;

  task automatic check(input int k, input string name,
                       input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got %h expected %h", k, name, got, want);
    end
  endtask

  // Reference: decimal digits of v mod 10^d, plus overflow flag in bit 40
  function automatic logic [40:0] ref_model(input longint v, input int d);
    longint p;
    longint m;
    logic [39:0] b;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    m = v % p;
    b = '0;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {(v >= p), b};
  endfunction

  function automatic longint dir_val(input int k, input int i);
    longint t0 [4] = '{249, 0, 255, 100};
    longint t1 [4] = '{249, 99, 100, 0};
    longint t2 [4] = '{65535, 10000, 0, 9999};
    if (k == 0) return t0[i];
    if (k == 1) return t1[i];
    return t2[i];
  endfunction

  for (genvar K = 0; K < 3; K++) begin : g_cfg
    localparam int W = (K == 2) ? 16 : 8;
    localparam int D = (K == 0) ? 3 : ((K == 1) ? 2 : 5);

    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     bin = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4*D-1:0]   bcd;
    logic             ovf;
    logic [40:0]      q [$];
    int               mode = 0;   // 0: ready high, 1: random, 2: ready low
    logic             done_b = 1'b0;

    assign done[K] = done_b;

    binary_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .binary_in_i (bin),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .bcd_out_o   (bcd),
      .bcd_ovf_o   (ovf)
    );

    // Downstream ready generator
    initial begin
      forever begin
        @(posedge clk);
        #2;
        if (mode == 0)      out_ready = 1'b1;
        else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                out_ready = 1'b0;
      end
    end

    // Monitor: every transfer pops one expected result
    initial begin
      logic [40:0] act;
      logic [40:0] exp_v;
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          act = '0;
          act[4*D-1:0] = bcd;
          act[40] = ovf;
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg%0d unexpected_result: got %h expected none", K, act);
          end else begin
            exp_v = q.pop_front();
            check(K, "result", 64'(act), 64'(exp_v));
          end
        end
      end
    end

    // Issue one value; measure edges from accept to out_valid.
    // With junk set, in_valid stays high with a different value afterwards.
    task automatic send(input longint v, input bit junk);
      int t;
      int edges;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      bin = W'(v);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 400) begin
          n_cmp++;
          n_fail++;
          $display("FAIL cfg%0d accept_timeout: got no in_ready expected in_ready", K);
          in_valid = 1'b0;
          return;
        end
      end
      q.push_back(ref_model(v, D));
      @(posedge clk);
      edges = 1;
      #1;
      if (junk) bin = ~bin;
      else      in_valid = 1'b0;
      forever begin
        @(negedge clk);
        if (junk) check(K, "in_ready_busy", 64'(in_ready), 64'(0));
        if (out_valid || edges > W + 4) break;
        @(posedge clk);
        edges++;
      end
      check(K, "latency", 64'(edges), 64'(W + 1));
    endtask

    task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      check(K, "drain", 64'(q.size()), 64'(0));
    endtask

    initial begin
      longint mask;
      longint v;
      logic [40:0] e;
      int t;
      mask = (longint'(1) << W) - 1;

      // Reset behaviour
      @(posedge clk);
      @(negedge clk);
      check(K, "in_ready_in_rst", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check(K, "rst_out_valid", 64'(out_valid), 64'(0));
      check(K, "rst_bcd", 64'(bcd), 64'(0));
      check(K, "rst_ovf", 64'(ovf), 64'(0));
      check(K, "rst_in_ready", 64'(in_ready), 64'(1));

      // Directed boundary values and sweep
      for (int i = 0; i < 4; i++) send(dir_val(K, i), 1'b0);
      for (int i = 0; i < 256; i++) send(longint'(i), 1'b0);

      // Random values with random backpressure
      mode = 1;
      for (int i = 0; i < 120; i++) begin
        v = longint'($urandom) & mask;
        send(v, 1'b0);
      end
      mode = 0;
      drain();

      // Held backpressure with ignored in_valid pulses
      mode = 2;
      v = longint'($urandom) & mask;
      e = ref_model(v, D);
      send(v, 1'b1);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        check(K, "bp_out_valid", 64'(out_valid), 64'(1));
        check(K, "bp_bcd_hold", 64'({ovf, bcd}), 64'({e[40], e[4*D-1:0]}));
        check(K, "bp_in_ready", 64'(in_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mode = 0;
      @(negedge clk);       // transfer happens at the next edge
      @(negedge clk);
      check(K, "post_xfer_in_ready", 64'(in_ready), 64'(1));
      check(K, "post_xfer_out_valid", 64'(out_valid), 64'(0));
      check(K, "post_xfer_hold", 64'({ovf, bcd}), 64'({e[40], e[4*D-1:0]}));
      drain();

      // Reset during the fourth shift cycle aborts the conversion
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      bin = W'(mask);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready || t > 400) break;
        t++;
      end
      check(K, "abort_accept", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check(K, "abort_out_valid", 64'(out_valid), 64'(0));
      check(K, "abort_bcd", 64'(bcd), 64'(0));
      check(K, "abort_ovf", 64'(ovf), 64'(0));
      check(K, "abort_in_ready", 64'(in_ready), 64'(1));
      send(42, 1'b0);
      drain();
      repeat (3) @(negedge clk);
      done_b = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      if (&done) break;
    end
    if (!(&done)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL global_timeout: got done=%b expected 111", done);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
